arbitro_alu: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational ALU (8 opcodes: ADD, SUB, AND, OR, XOR, SRA, SRL, NOR; 6-bit function code).
- Accepts operand/opcode transactions from two independent requesters over valid/ready handshakes and grants the ALU round-robin.
- Drives the ALU inputs from registered operands, captures the result, and returns it tagged with the requester ID over a valid/ready result port.
- Sits between the control/UART front ends and the single ALU instance.

---
 rtl/arbitro_alu_if.sv | 55 +++++
 rtl/arbitro_alu.sv | 124 ++++++++++++
 tb/tb_arbitro_alu.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_alu_if.sv
// Bus bundle for arbitro_alu: two requester ports, the ALU drive/return pair and the result port.
// slave is the arbiter view; master is the requester/ALU/consumer view.
interface arbitro_alu_if #(
   parameter int unsigned nbits = 8
);
   localparam int unsigned opw = 6;

   logic             req0_valid;
   logic [nbits-1:0] req0_a;
   logic [nbits-1:0] req0_b;
   logic [opw-1:0]   req0_op;
   logic             req0_ready;

   logic             req1_valid;
   logic [nbits-1:0] req1_a;
   logic [nbits-1:0] req1_b;
   logic [opw-1:0]   req1_op;
   logic             req1_ready;

   logic [nbits-1:0] alu_a;
   logic [nbits-1:0] alu_b;
   logic [opw-1:0]   alu_op;
   logic [nbits-1:0] alu_r;

   logic             res_valid;
   logic [nbits-1:0] res_data;
   logic             res_id;
   logic             res_err;
   logic             res_ready;
   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output alu_a, alu_b, alu_op,
      input  alu_r,
      output res_valid, res_data, res_id, res_err,
      input  res_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  alu_a, alu_b, alu_op,
      output alu_r,
      input  res_valid, res_data, res_id, res_err,
      output res_ready,
      input  busy
   );
endinterface

// File: rtl/arbitro_alu.sv
// Round-robin two-requester arbiter/sequencer in front of a shared combinational ALU.
// Optional macro ARBITRO_ALU_OPCHK_EN: flag illegal opcodes and force their result to zero.
module arbitro_alu #(
   parameter int unsigned nbits = 8
) (
   input  logic          clk,
   input  logic          reset,
   arbitro_alu_if.slave  bus
);
   localparam int unsigned opw = 6;

   typedef enum logic [1:0] {
      idle = 2'd0,
      calc = 2'd1,
      resp = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             busy_c;
   logic             res_valid_c;
   logic [nbits-1:0] sel_a;
   logic [nbits-1:0] sel_b;
   logic [opw-1:0]   sel_op;
   logic [nbits-1:0] alu_a_q;
   logic [nbits-1:0] alu_b_q;
   logic [opw-1:0]   alu_op_q;
   logic [nbits-1:0] res_data_q;
   logic             res_id_q;
   logic             res_err_q;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= idle;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         idle:    if (accept) state_nxt = calc;
         calc:    state_nxt = resp;
         resp:    if (bus.res_ready) state_nxt = idle;
         default: state_nxt = idle;
      endcase
   end

   // grants and state-derived outputs; ready is only ever offered from idle
   always_comb begin
      grant0      = 1'b0;
      grant1      = 1'b0;
      busy_c      = (state != idle);
      res_valid_c = (state == resp);
      if ((state == idle) && !reset) begin
         grant0 = bus.req0_valid & (~bus.req1_valid | last);
         grant1 = bus.req1_valid & ~grant0;
      end
      accept = grant0 | grant1;
      sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
      sel_b  = grant1 ? bus.req1_b  : bus.req0_b;
      sel_op = grant1 ? bus.req1_op : bus.req0_op;
   end

   // ALU input registers, requester tag and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         res_id_q <= 1'b0;
         last     <= 1'b1;
      end else if (accept) begin
         alu_a_q  <= sel_a;
         alu_b_q  <= sel_b;
         alu_op_q <= sel_op;
         res_id_q <= grant1;
         last     <= grant1;
      end
   end

`ifdef ARBITRO_ALU_OPCHK_EN
   logic op_bad_q;

   always_ff @(posedge clk) begin
      if (reset)       op_bad_q <= 1'b0;
      else if (accept) op_bad_q <= !(sel_op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                                    6'b100110, 6'b000011, 6'b000010, 6'b100111});
   end

   // result capture; an illegal opcode overrides whatever the ALU returned
   always_ff @(posedge clk) begin
      if (reset) begin
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else if (state == calc) begin
         res_data_q <= op_bad_q ? '0 : bus.alu_r;
         res_err_q  <= op_bad_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset)              res_data_q <= '0;
      else if (state == calc) res_data_q <= bus.alu_r;
   end

   assign res_err_q = 1'b0;
`endif

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.res_valid  = res_valid_c;
   assign bus.res_data   = res_data_q;
   assign bus.res_id     = res_id_q;
   assign bus.res_err    = res_err_q;
   assign bus.busy       = busy_c;
endmodule

// File: tb/tb_arbitro_alu.sv
// Bench for arbitro_alu: directed scenarios plus randomized traffic against a transaction-level model.
// Also provides the combinational ALU the arbiter drives.
module tb_arbitro_alu;
   localparam int unsigned nb = 8;
   localparam logic [5:0] legal_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                             6'b100110, 6'b000011, 6'b000010, 6'b100111};

   logic clk;
   logic reset;
   int   checks;
   int   passed;

   arbitro_alu_if #(.nbits(nb)) bus ();
   arbitro_alu #(.nbits(nb)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shared ALU stand-in
   always_comb begin
      case (bus.alu_op)
         6'b100000: bus.alu_r = bus.alu_a + bus.alu_b;
         6'b100010: bus.alu_r = bus.alu_a - bus.alu_b;
         6'b100100: bus.alu_r = bus.alu_a & bus.alu_b;
         6'b100101: bus.alu_r = bus.alu_a | bus.alu_b;
         6'b100110: bus.alu_r = bus.alu_a ^ bus.alu_b;
         6'b000011: bus.alu_r = nb'($signed(bus.alu_a) >>> bus.alu_b);
         6'b000010: bus.alu_r = bus.alu_a >> bus.alu_b;
         6'b100111: bus.alu_r = ~(bus.alu_a | bus.alu_b);
         default:   bus.alu_r = '0;
      endcase
   end

   function automatic bit is_legal(input logic [5:0] op);
      for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // expected result from integer arithmetic on the transaction operands
   function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      int ia = int'(a);
      int ib = int'(b);
      int sa = (ia >= 128) ? ia - 256 : ia;
      int r  = 0;
      if      (op == 6'b100000) r = (ia + ib) % 256;
      else if (op == 6'b100010) r = (ia - ib + 256) % 256;
      else if (op == 6'b100100) r = int'(a & b);
      else if (op == 6'b100101) r = int'(a | b);
      else if (op == 6'b100110) r = int'(a ^ b);
      else if (op == 6'b000011) r = (ib >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ib) & 255);
      else if (op == 6'b000010) r = (ib >= 8) ? 0 : (ia >> ib);
      else if (op == 6'b100111) r = 255 - int'(a | b);
`ifdef ARBITRO_ALU_OPCHK_EN
      if (!is_legal(op)) r = 0;
`endif
      return 8'(r);
   endfunction

   function automatic logic exp_err(input logic [5:0] op);
`ifdef ARBITRO_ALU_OPCHK_EN
      return !is_legal(op);
`else
      return 1'b0 & op[0];
`endif
   endfunction

   task automatic idle_inputs;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.res_ready  = 1'b1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      bus.req0_valid = 1'b1; bus.req0_op = 6'b100000;
      bus.req1_valid = 1'b1; bus.req1_op = 6'b100110;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
         $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
      else passed++;
      checks++;
      if ({bus.busy, bus.res_valid, bus.res_id, bus.res_err} !== 4'b0000)
         $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.res_valid, bus.res_id, bus.res_err});
      else passed++;
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data} !== 30'd0)
         $display("FAIL reset_data got %h %h %b %h want zeros", bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data);
      else passed++;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 8'd5; bus.req0_b = 8'd3; bus.req0_op = 6'b100000;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b100)
         $display("FAIL single_accept got %b want 100", {bus.req0_ready, bus.req1_ready, bus.busy});
      else passed++;
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      checks++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.busy, bus.res_valid} !== {6'b100000, 8'd5, 8'd3, 2'b10})
         $display("FAIL single_calc got op=%b a=%0d b=%0d busy=%b rv=%b want op=100000 a=5 b=3 busy=1 rv=0",
                  bus.alu_op, bus.alu_a, bus.alu_b, bus.busy, bus.res_valid);
      else passed++;
      @(negedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_err} !== {1'b1, 8'd8, 1'b0, 1'b0})
         $display("FAIL single_resp got rv=%b data=%0d id=%b err=%b want 1 8 0 0",
                  bus.res_valid, bus.res_data, bus.res_id, bus.res_err);
      else passed++;
      @(negedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.busy} !== 2'b00)
         $display("FAIL single_idle got rv=%b busy=%b want 0 0", bus.res_valid, bus.busy);
      else passed++;
   endtask

   task automatic test_contention;
      int n;
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_a = 8'd10;   bus.req0_b = 8'd3;   bus.req0_op = 6'b100010;
      bus.req1_valid = 1'b1; bus.req1_a = 8'hF0;   bus.req1_b = 8'h0F;  bus.req1_op = 6'b100110;
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!(bus.req0_ready | bus.req1_ready) && n < 8) begin
            @(negedge clk); #1; n++;
         end
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
            $display("FAIL contention_grant%0d got %b want %b", k, {bus.req0_ready, bus.req1_ready},
                     (k % 2 == 0) ? 2'b10 : 2'b01);
         else passed++;
         if (k > 0) begin
            checks++;
            if (n !== 0) $display("FAIL contention_interval%0d got %0d idle waits want 0", k, n);
            else passed++;
         end
         @(negedge clk); #1;
         @(negedge clk); #1;
         checks++;
         if ({bus.res_valid, bus.res_data, bus.res_id} !== ((k % 2 == 0) ? {1'b1, 8'd7, 1'b0} : {1'b1, 8'hFF, 1'b1}))
            $display("FAIL contention_result%0d got rv=%b data=%h id=%b", k, bus.res_valid, bus.res_data, bus.res_id);
         else passed++;
         @(negedge clk); #1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      int xfers;
      @(negedge clk);
      bus.req1_valid = 1'b1; bus.req1_a = 8'd0; bus.req1_b = 8'd0; bus.req1_op = 6'b100111;
      bus.res_ready  = 1'b0;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
         $display("FAIL bp_accept got %b want 01", {bus.req0_ready, bus.req1_ready});
      else passed++;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_op = 6'b100000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({bus.res_valid, bus.res_data, bus.res_id, bus.req0_ready, bus.req1_ready} !== {1'b1, 8'hFF, 1'b1, 2'b00})
            $display("FAIL bp_stall%0d got rv=%b data=%h id=%b rdy=%b%b want 1 ff 1 00", i,
                     bus.res_valid, bus.res_data, bus.res_id, bus.req0_ready, bus.req1_ready);
         else passed++;
      end
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.res_ready  = 1'b1;
      xfers = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (bus.res_valid && bus.res_ready) xfers++;
         @(negedge clk);
      end
      checks++;
      if (xfers !== 1) $display("FAIL bp_transfers got %0d want 1", xfers);
      else passed++;
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 8'hF0; bus.req0_b = 8'h3C; bus.req0_op = 6'b100100;
      bus.res_ready  = 1'b1;
      @(negedge clk);
      bus.req0_valid = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL rstmid_in_calc got busy=%b want 1", bus.busy);
      else passed++;
      @(negedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data, bus.res_id, bus.res_err,
           bus.req0_ready, bus.req1_ready} !== 38'd0)
         $display("FAIL rstmid_outputs got rv=%b busy=%b a=%h b=%h op=%b d=%h id=%b err=%b want all 0",
                  bus.res_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data, bus.res_id, bus.res_err);
      else passed++;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (bus.res_valid) seen++;
      end
      checks++;
      if (seen !== 0) $display("FAIL rstmid_no_result got %0d res_valid cycles want 0", seen);
      else passed++;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_op = 6'b100101;
      bus.req1_valid = 1'b1; bus.req1_op = 6'b100101;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
         $display("FAIL rstmid_first_grant got %b want 10", {bus.req0_ready, bus.req1_ready});
      else passed++;
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_illegal;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 8'd4; bus.req0_b = 8'd4; bus.req0_op = 6'b111111;
      bus.res_ready  = 1'b1;
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_err} !== {1'b1, 8'd0, 1'b0, exp_err(6'b111111)})
         $display("FAIL illegal_op got rv=%b data=%h id=%b err=%b want 1 00 0 %b",
                  bus.res_valid, bus.res_data, bus.res_id, bus.res_err, exp_err(6'b111111));
      else passed++;
      @(negedge clk);
   endtask

   // randomized traffic against a transaction-level model: grant rule, latency, one result per grant
   task automatic test_random(input int ncyc);
      logic [9:0] expq[$];
      logic       prio;
      int         phase;
      logic       e0;
      logic       e1;
      do_reset();
      prio  = 1'b0;
      phase = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         bus.req0_valid = ($urandom_range(0, 2) != 0);
         bus.req0_a     = 8'($urandom);
         bus.req0_b     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
         bus.req0_op    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
         bus.req1_valid = ($urandom_range(0, 2) != 0);
         bus.req1_a     = 8'($urandom);
         bus.req1_b     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
         bus.req1_op    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
         bus.res_ready  = ($urandom_range(0, 3) != 0);
         #1;
         e0 = (phase == 0) && bus.req0_valid && (!bus.req1_valid || prio == 1'b0);
         e1 = (phase == 0) && bus.req1_valid && !e0;
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== {e0, e1})
            $display("FAIL rand_grant c%0d got %b want %b", c, {bus.req0_ready, bus.req1_ready}, {e0, e1});
         else passed++;
         checks++;
         if (bus.res_valid !== (phase == 2))
            $display("FAIL rand_valid c%0d got %b want %b", c, bus.res_valid, (phase == 2));
         else passed++;
         if (phase == 2 && expq.size() > 0) begin
            checks++;
            if ({bus.res_data, bus.res_id, bus.res_err} !== expq[0])
               $display("FAIL rand_result c%0d got data=%h id=%b err=%b want data=%h id=%b err=%b", c,
                        bus.res_data, bus.res_id, bus.res_err, expq[0][9:2], expq[0][1], expq[0][0]);
            else passed++;
         end
         if (phase == 0 && (e0 || e1)) begin
            if (e0) expq.push_back({ref_result(bus.req0_a, bus.req0_b, bus.req0_op), 1'b0, exp_err(bus.req0_op)});
            else    expq.push_back({ref_result(bus.req1_a, bus.req1_b, bus.req1_op), 1'b1, exp_err(bus.req1_op)});
            prio  = e0;
            phase = 1;
         end else if (phase == 1) begin
            phase = 2;
         end else if (phase == 2 && bus.res_ready) begin
            void'(expq.pop_front());
            phase = 0;
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_illegal();
      test_random(600);
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
